// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory
// combinationally, and queues {PC, instruction} pairs in a small FIFO that
// decode drains through a valid/ready handshake. A taken branch or jump from
// EX flushes the FIFO and restarts fetching at the aligned target.
//
// Handshake: IF_VALID says the FIFO head holds an instruction. A transfer
// happens on a rising edge where IF_VALID and IF_READY are both high and no
// redirect is present. While IF_VALID is high and IF_READY is low, the head
// (IF_PC, IF_INSTRUCTION) holds stable. A redirect at the same edge discards
// the transfer.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_INSTRUCTION,
    output logic        IF_VALID,
    input  logic        IF_READY,
    output logic [31:0] IF_INSTRUCTION,
    output logic [31:0] IF_PC,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic pop;
    logic fetch;

    // The target's byte offset within the word is dropped on redirect.
    logic [1:0] unused_target_lsbs;
    assign unused_target_lsbs = BRANCH_TARGET[1:0];

    // Next-state logic: redirect flushes and retargets, otherwise fetch/pop.
    always_comb begin
        pop        = (count_q != '0) && IF_READY;
        fetch      = !BRANCH_TAKEN && ((count_q < DEPTH_C) || pop);
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (BRANCH_TAKEN) begin
            fetch_pc_d = {BRANCH_TARGET[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (fetch && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !fetch) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state: fetch PC, FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (fetch) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= IMEM_INSTRUCTION;
        end
    end

    assign IMEM_ADDRESS   = fetch_pc_q;
    assign IF_VALID       = (count_q != '0);
    assign IF_INSTRUCTION = IF_VALID ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign IF_PC          = IF_VALID ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-memory read interface.
- Holds the fetch PC and drives a byte address to the instruction memory, which returns the instruction combinationally in the same cycle.
- Buffers fetched {PC, instruction} pairs in a small FIFO and hands them to decode with a valid/ready handshake.
- Sits between instruction memory and the IF/ID stage of the RV32IM pipeline; EX redirects it on taken branches and jumps.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- DEPTH, 2, fetch buffer entries; power of two, ≥ 2.
- NOP_INSTR, 32'h00000013, value driven on IF_INSTRUCTION when the buffer is empty.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IMEM_ADDRESS  output  32  byte address of the word being fetched; equals FETCH_PC.
- IMEM_INSTRUCTION  input  32  instruction word at IMEM_ADDRESS, valid in the same cycle.
- IF_VALID  output  1  buffer head holds a valid instruction.
- IF_READY  input  1  decode accepts the head this cycle.
- IF_INSTRUCTION  output  32  instruction at the buffer head; NOP_INSTR when empty.
- IF_PC  output  32  PC of the head instruction; 0 when empty.
- BRANCH_TAKEN  input  1  redirect request, sampled at the rising edge.
- BRANCH_TARGET  input  32  redirect byte address.

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - FETCH_PC = RESET_PC, buffer count = 0, read/write pointers = 0.
  - IF_VALID = 0, IF_INSTRUCTION = NOP_INSTR, IF_PC = 0, IMEM_ADDRESS = RESET_PC.
- Internal signals:
  - pop = IF_VALID && IF_READY.
  - fetch = !BRANCH_TAKEN && (count < DEPTH || pop).
- On a fetch edge:
  - push {FETCH_PC, IMEM_INSTRUCTION} at the write pointer.
  - FETCH_PC <= FETCH_PC + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- When fetch = 0 and no redirect, FETCH_PC holds. IMEM_ADDRESS repeats the same address, and the same word is re-read when space frees.
- Pop advances the read pointer; pointers wrap modulo DEPTH.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, including when full.
- Outputs come from registered buffer storage; there is no combinational path from IMEM_INSTRUCTION to IF_INSTRUCTION.
- IF_VALID = (count != 0). While IF_VALID = 1 and IF_READY = 0, IF_INSTRUCTION and IF_PC hold stable.
- Redirect (BRANCH_TAKEN = 1 at an edge):
  - Flush: count <= 0, pointers <= 0; IF_VALID = 0 the next cycle.
  - FETCH_PC <= {BRANCH_TARGET[31:2], 2'b00}; low two bits are ignored.
  - No push that cycle. Any concurrent pop is discarded, because the flush takes priority.
  - Redirect wins over everything except RESET.
- Latency:
  - Fetch to IF_VALID is 1 edge.
  - Redirect edge to first target instruction valid is 2 edges.
  - Reset release to first valid (RESET_PC) is 1 edge.
- Throughput: with IF_READY held high, one instruction per cycle and no bubbles.
- Full buffer with IF_READY = 0: no fetch; FETCH_PC holds at the next unfetched address.
- Back-to-back redirects: each one flushes, and the last one wins.

Test Plan:
Bench memory model returns IMEM_INSTRUCTION = 32'hA0000000 | IMEM_ADDRESS.
- Reset release, IF_READY = 1 held → IF_VALID rises after edge 1. IF_PC sequence 0, 4, 8, 12 on consecutive cycles, with IF_INSTRUCTION = 32'hA0000000, A0000004, A0000008, A000000C.
- IF_READY = 0 for 5 cycles after reset → buffer fills (DEPTH = 2). IF_PC holds 0 and IMEM_ADDRESS holds 8. On IF_READY = 1, IF_PC = 0, 4, 8 is delivered with no gap and no skipped or duplicated PC.
- BRANCH_TAKEN = 1 with BRANCH_TARGET = 32'h00000102 while the buffer is full and IF_READY = 1 → IF_VALID = 0 the next cycle. The next valid head has IF_PC = 32'h100 and IF_INSTRUCTION = 32'hA0000100. Old PCs never appear.
- RESET_PC = 32'hFFFFFFF8, IF_READY = 1 → IF_PC = FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- RESET asserted asynchronously mid-stream (between clock edges) → IF_VALID = 0, IF_INSTRUCTION = 32'h00000013 and IMEM_ADDRESS = RESET_PC immediately. After release, delivery restarts from RESET_PC.
- Random IF_READY (50%) plus sparse random redirects, checked against a reference model → delivered PC stream is exactly sequential runs from each target, with no loss or duplication.
